// File: rtl/ase_ccip_rsp_engine_pkg.sv
// ase_ccip_rsp_engine_pkg: CCI-P header types, response-queue entry format and FSM states
// shared by ase_ccip_rsp_engine and ase_rsp_fifo.
// Optional macro ASE_RAND_LATENCY_EN adds a 3-bit extra-latency field to each queue entry.
package ase_ccip_rsp_engine_pkg;

    // Virtual channels
    localparam logic [1:0] VC_VA  = 2'd0;
    localparam logic [1:0] VC_VL0 = 2'd1;
    localparam logic [1:0] VC_VH0 = 2'd2;
    localparam logic [1:0] VC_VH1 = 2'd3;

    // Cache-line counts (len encodes beats-1)
    localparam logic [1:0] ASE_1CL = 2'd0;
    localparam logic [1:0] ASE_2CL = 2'd1;
    localparam logic [1:0] ASE_4CL = 2'd3;

    // Request types
    localparam logic [3:0] ASE_WRLINE_M   = 4'h1;
    localparam logic [3:0] ASE_WRLINE_I   = 4'h2;
    localparam logic [3:0] ASE_RDLINE_S   = 4'h4;
    localparam logic [3:0] ASE_WRFENCE    = 4'h5;
    localparam logic [3:0] ASE_RDLINE_I   = 4'h6;
    localparam logic [3:0] ASE_INTR_REQ   = 4'h8;
    localparam logic [3:0] ASE_ATOMIC_REQ = 4'h9;

    // Response types
    localparam logic [3:0] ASE_RD_RSP      = 4'h0;
    localparam logic [3:0] ASE_WR_RSP      = 4'h1;
    localparam logic [3:0] ASE_INTR_RSP    = 4'h4;
    localparam logic [3:0] ASE_WRFENCE_RSP = 4'h5;

    typedef struct packed {
        logic [1:0]  vc;
        logic        sop;
        logic [1:0]  len;
        logic [3:0]  reqtype;
        logic [15:0] mdata;
    } TxHdr_t;

    typedef struct packed {
        logic   channel_id;
        TxHdr_t txhdr;
    } ASETxHdr_t;

    typedef struct packed {
        logic [1:0]  vc_used;
        logic        poison;
        logic        hitmiss;
        logic        format;
        logic        rsvd22;
        logic [1:0]  clnum;
        logic [3:0]  resptype;
        logic [15:0] mdata;
    } RxHdr_t;

    typedef struct packed {
        logic   channel_id;
        RxHdr_t rxhdr;
    } ASERxHdr_t;

    localparam int ASE_TX_HDR_WIDTH = $bits(ASETxHdr_t);
    localparam int ASE_RX_HDR_WIDTH = $bits(ASERxHdr_t);
    localparam int ASE_RSP_TS_WIDTH = 16;

    // One queued response: header template, enqueue timestamp and beats-1.
    typedef struct packed {
        RxHdr_t                      tmpl;
        logic [ASE_RSP_TS_WIDTH-1:0] ts;
        logic [1:0]                  len;
`ifdef ASE_RAND_LATENCY_EN
        logic [2:0]                  xlat;
`endif
    } ase_rsp_entry_t;

    typedef enum logic {SEQ_IDLE, SEQ_EXPAND} rsp_seq_state_t;
    typedef enum logic {WR_IDLE, WR_BURST} wr_trk_state_t;

    // VA is resolved by the host; responses report it as VL0.
    function automatic logic [1:0] ase_vc_map(input logic [1:0] vc);
        return (vc == VC_VA) ? VC_VL0 : vc;
    endfunction

endpackage

// File: rtl/ase_rsp_fifo.sv
// ase_rsp_fifo: synchronous DEPTH x ase_rsp_entry_t FIFO with occupancy, full, empty and
// registered almost-full (from next-state occupancy).
// Ports: clk, rst_n (async, active-low); push/din write, pop/dout read (dout = head);
// count, full, empty, almfull status.
module ase_rsp_fifo
    import ase_ccip_rsp_engine_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int FULL_THRESH = DEPTH - 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  ase_rsp_entry_t           din,
    input  logic                     pop,
    output ase_rsp_entry_t           dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almfull
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0] THRESH_C = (AW+1)'(FULL_THRESH);

    ase_rsp_entry_t mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q, count_d;
    logic           almfull_q, almfull_d, push_ok, pop_ok;

    // A push while full is dropped even if a pop happens in the same cycle.
    always_comb begin
        push_ok   = push && (count_q != DEPTH_C);
        pop_ok    = pop && (count_q != '0);
        wr_ptr_d  = wr_ptr_q + AW'(push_ok);
        rd_ptr_d  = rd_ptr_q + AW'(pop_ok);
        count_d   = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        almfull_d = count_d >= THRESH_C;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            almfull_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            almfull_q <= almfull_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = count_q == DEPTH_C;
    assign empty   = count_q == '0;
    assign almfull = almfull_q;

endmodule

// File: rtl/ase_ccip_rsp_engine.sv
// ase_ccip_rsp_engine: host-side CCI-P responder; turns channel-tagged Tx headers into
// in-order Rx response headers no earlier than LATENCY cycles after acceptance.
// Ports: clk, rst_n (async, active-low); req_valid/req_hdr request in (no backpressure),
// req_almfull queue almost full; rsp_valid/rsp_hdr/rsp_ready response handshake;
// err_proto one-cycle protocol-violation pulse; err_overflow sticky enqueue-while-full flag.
// Macro ASE_RAND_LATENCY_EN: per-entry extra latency 0..7 from a 16-bit LFSR.
module ase_ccip_rsp_engine
    import ase_ccip_rsp_engine_pkg::*;
#(
    parameter int LATENCY     = 8,
    parameter int DEPTH       = 32,
    parameter int FULL_THRESH = DEPTH - 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    input  logic [ASE_TX_HDR_WIDTH-1:0] req_hdr,
    output logic                        req_almfull,
    output logic                        rsp_valid,
    output logic [ASE_RX_HDR_WIDTH-1:0] rsp_hdr,
    input  logic                        rsp_ready,
    output logic                        err_proto,
    output logic                        err_overflow
);
    localparam logic [15:0] LAT_C = 16'(LATENCY);

    ASETxHdr_t                req;
    TxHdr_t                   tx;
    logic                     is_rd, is_wr, is_fence, is_intr;
    logic                     push, pop, proto, elig, last;
    logic                     fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0]   fifo_count_unused;
    ase_rsp_entry_t           push_entry, head;
    RxHdr_t                   tmpl;
    logic [15:0]              ts_q, ts_d, lat_need;
    wr_trk_state_t            wr_state_q, wr_state_d;
    logic [1:0]               wr_cnt_q, wr_cnt_d, wr_len_q, wr_len_d, wr_vc_q, wr_vc_d;
    logic [15:0]              wr_mdata_q, wr_mdata_d;
    rsp_seq_state_t           seq_q, seq_d;
    logic [1:0]               beat_q, beat_d;
    logic                     rsp_valid_q, rsp_valid_d;
    ASERxHdr_t                rsp_hdr_q, rsp_hdr_d;
    logic                     err_proto_q, err_proto_d, err_overflow_q, err_overflow_d;
`ifdef ASE_RAND_LATENCY_EN
    logic [15:0]              lfsr_q, lfsr_d;
`endif

    assign req = req_hdr;
    assign tx  = req.txhdr;

    always_comb begin
        is_rd    = req_valid && !req.channel_id &&
                   (tx.reqtype == ASE_RDLINE_S || tx.reqtype == ASE_RDLINE_I);
        is_wr    = req_valid && req.channel_id &&
                   (tx.reqtype == ASE_WRLINE_I || tx.reqtype == ASE_WRLINE_M);
        is_fence = req_valid && req.channel_id && tx.reqtype == ASE_WRFENCE;
        is_intr  = req_valid && req.channel_id && tx.reqtype == ASE_INTR_REQ;
    end

    // Request decode and write tracker: builds the entry to enqueue this cycle.
    always_comb begin
        tmpl            = '0;
        tmpl.vc_used    = ase_vc_map(tx.vc);
        tmpl.mdata      = tx.mdata;
        tmpl.resptype   = is_rd ? ASE_RD_RSP : is_fence ? ASE_WRFENCE_RSP :
                          is_intr ? ASE_INTR_RSP : ASE_WR_RSP;
        push            = is_rd || is_fence || is_intr;
        proto           = req_valid && !(is_rd || is_wr || is_fence || is_intr);
        wr_state_d      = wr_state_q;
        wr_cnt_d        = wr_cnt_q;
        wr_len_d        = wr_len_q;
        wr_vc_d         = wr_vc_q;
        wr_mdata_d      = wr_mdata_q;
        if (is_wr && tx.sop) begin
            // A new sop while a burst is open abandons the old burst.
            proto      = wr_state_q == WR_BURST;
            push       = tx.len == ASE_1CL;
            wr_state_d = (tx.len == ASE_1CL) ? WR_IDLE : WR_BURST;
            wr_cnt_d   = tx.len;
            wr_len_d   = tx.len;
            wr_vc_d    = tx.vc;
            wr_mdata_d = tx.mdata;
        end else if (is_wr && wr_state_q == WR_IDLE) begin
            proto = 1'b1;
        end else if (is_wr) begin
            wr_cnt_d = wr_cnt_q - 2'd1;
            if (wr_cnt_q == 2'd1) begin
                push          = 1'b1;
                wr_state_d    = WR_IDLE;
                tmpl.vc_used  = ase_vc_map(wr_vc_q);
                tmpl.mdata    = wr_mdata_q;
                tmpl.format   = 1'b1;
                tmpl.clnum    = wr_len_q;
            end
        end
        push_entry      = '0;
        push_entry.tmpl = tmpl;
        push_entry.ts   = ts_q;
        // Only reads expand into multiple beats; everything else is one beat.
        push_entry.len  = is_rd ? tx.len : ASE_1CL;
`ifdef ASE_RAND_LATENCY_EN
        push_entry.xlat = lfsr_q[2:0];
`endif
    end

    ase_rsp_fifo #(
        .DEPTH       (DEPTH),
        .FULL_THRESH (FULL_THRESH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .din     (push_entry),
        .pop     (pop),
        .dout    (head),
        .count   (fifo_count_unused),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .almfull (req_almfull)
    );

    // Response sequencer. Eligibility is evaluated against next cycle's timestamp so the
    // registered rsp_valid rises exactly LATENCY cycles after enqueue.
    always_comb begin
`ifdef ASE_RAND_LATENCY_EN
        lat_need = LAT_C + {13'd0, head.xlat};
        lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
`else
        lat_need = LAT_C;
`endif
        ts_d           = ts_q + 16'd1;
        elig           = !fifo_empty && ((ts_d - head.ts) >= lat_need);
        last           = beat_q == head.len;
        pop            = seq_q == SEQ_EXPAND && rsp_ready && last;
        seq_d          = seq_q;
        beat_d         = beat_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_hdr_d      = rsp_hdr_q;
        if (seq_q == SEQ_IDLE && elig) begin
            seq_d       = SEQ_EXPAND;
            beat_d      = 2'd0;
            rsp_valid_d = 1'b1;
            rsp_hdr_d   = {head.tmpl.resptype != ASE_RD_RSP, head.tmpl};
        end else if (seq_q == SEQ_EXPAND && rsp_ready) begin
            seq_d                 = last ? SEQ_IDLE : SEQ_EXPAND;
            rsp_valid_d           = !last;
            beat_d                = beat_q + 2'd1;
            rsp_hdr_d.rxhdr.clnum = rsp_hdr_q.rxhdr.clnum + 2'd1;
        end
        err_proto_d    = proto;
        err_overflow_d = err_overflow_q || (push && fifo_full);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q           <= '0;
            wr_state_q     <= WR_IDLE;
            wr_cnt_q       <= '0;
            wr_len_q       <= '0;
            wr_vc_q        <= '0;
            wr_mdata_q     <= '0;
            seq_q          <= SEQ_IDLE;
            beat_q         <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_hdr_q      <= '0;
            err_proto_q    <= 1'b0;
            err_overflow_q <= 1'b0;
`ifdef ASE_RAND_LATENCY_EN
            lfsr_q         <= 16'hACE1;
`endif
        end else begin
            ts_q           <= ts_d;
            wr_state_q     <= wr_state_d;
            wr_cnt_q       <= wr_cnt_d;
            wr_len_q       <= wr_len_d;
            wr_vc_q        <= wr_vc_d;
            wr_mdata_q     <= wr_mdata_d;
            seq_q          <= seq_d;
            beat_q         <= beat_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_hdr_q      <= rsp_hdr_d;
            err_proto_q    <= err_proto_d;
            err_overflow_q <= err_overflow_d;
`ifdef ASE_RAND_LATENCY_EN
            lfsr_q         <= lfsr_d;
`endif
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_hdr      = rsp_hdr_q;
    assign err_proto    = err_proto_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_ase_ccip_rsp_engine.sv
// tb_ase_ccip_rsp_engine: directed scoreboard bench for ase_ccip_rsp_engine (LATENCY=8, DEPTH=32).
module tb_ase_ccip_rsp_engine;
    import ase_ccip_rsp_engine_pkg::*;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        req_valid = 1'b0;
    logic [ASE_TX_HDR_WIDTH-1:0] req_hdr = '0;
    logic                        req_almfull;
    logic                        rsp_valid;
    logic [ASE_RX_HDR_WIDTH-1:0] rsp_hdr;
    logic                        rsp_ready = 1'b1;
    logic                        err_proto;
    logic                        err_overflow;

    int        cyc = 0;
    int        checks = 0;
    int        errors = 0;
    int        hs_cnt = 0;
    bit        mon_en = 1'b1;
    ASERxHdr_t sb[$];

    ase_ccip_rsp_engine #(.LATENCY(8), .DEPTH(32), .FULL_THRESH(27)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_hdr      (req_hdr),
        .req_almfull  (req_almfull),
        .rsp_valid    (rsp_valid),
        .rsp_hdr      (rsp_hdr),
        .rsp_ready    (rsp_ready),
        .err_proto    (err_proto),
        .err_overflow (err_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ASERxHdr_t mk(input logic ch, input logic [3:0] rt, input logic [1:0] vc,
                                     input logic fmt, input logic [1:0] cl, input logic [15:0] md);
        ASERxHdr_t r;
        r                = '0;
        r.channel_id     = ch;
        r.rxhdr.vc_used  = vc;
        r.rxhdr.format   = fmt;
        r.rxhdr.clnum    = cl;
        r.rxhdr.resptype = rt;
        r.rxhdr.mdata    = md;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic ch, input logic [3:0] rt, input logic [1:0] len,
                        input logic sop, input logic [1:0] vc, input logic [15:0] md);
        ASETxHdr_t h;
        h.channel_id    = ch;
        h.txhdr.vc      = vc;
        h.txhdr.sop     = sop;
        h.txhdr.len     = len;
        h.txhdr.reqtype = rt;
        h.txhdr.mdata   = md;
        req_hdr   = h;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_rsp_valid", 32'(rsp_valid), 32'd1);
        c = cyc;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(sb.size()), 32'd0);
        @(negedge clk);
        chk({tag, "_idle"}, 32'(rsp_valid), 32'd0);
    endtask

    // Scoreboard side: every accepted beat must match the oldest expected header.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (mon_en) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL rsp_unexpected: observed %0h expected no response", rsp_hdr);
                end
                if (sb.size() != 0) begin
                    ASERxHdr_t e;
                    e = sb.pop_front();
                    chk("rsp_hdr", 32'(rsp_hdr), 32'(e));
                end
            end
        end
    end

    initial begin
        int t0, c, hs0;
        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_hdr", 32'(rsp_hdr), 32'd0);
        chk("rst_err_proto", 32'(err_proto), 32'd0);
        chk("rst_err_overflow", 32'(err_overflow), 32'd0);
        chk("rst_almfull", 32'(req_almfull), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single 1CL read on VA at cycle 10: response 8 cycles later, VA reported as VL0
        while (cyc < 10) tick();
        sb.push_back(mk(1'b0, ASE_RD_RSP, VC_VL0, 1'b0, 2'd0, 16'h00A5));
        t0 = cyc;
        send(1'b0, ASE_RDLINE_I, ASE_1CL, 1'b1, VC_VA, 16'h00A5);
        wait_valid(c);
        chk("rd1_latency", 32'(c - t0), 32'd8);
        drain("rd1_drain");

        // 4CL read, ready held high: four consecutive beats clnum 0..3
        tick();
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b0, ASE_RD_RSP, VC_VH0, 1'b0, 2'(i), 16'h0B0B));
        send(1'b0, ASE_RDLINE_S, ASE_4CL, 1'b1, VC_VH0, 16'h0B0B);
        wait_valid(c);
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("rd4_consecutive", 32'(rsp_valid), 32'd1);
        end
        drain("rd4_drain");

        // 4CL read with ready low for 3 cycles on beat 2: beat 2 held stable
        tick();
        for (int i = 0; i < 4; i++) sb.push_back(mk(1'b0, ASE_RD_RSP, VC_VH1, 1'b0, 2'(i), 16'h0C0C));
        send(1'b0, ASE_RDLINE_S, ASE_4CL, 1'b1, VC_VH1, 16'h0C0C);
        wait_valid(c);
        tick();
        tick();
        rsp_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_hdr", 32'(rsp_hdr), 32'(mk(1'b0, ASE_RD_RSP, VC_VH1, 1'b0, 2'd2, 16'h0C0C)));
        end
        tick();
        rsp_ready = 1'b1;
        drain("stall_drain");

        // 4CL write burst: one multi-CL response 8 cycles after the final beat
        tick();
        sb.push_back(mk(1'b1, ASE_WR_RSP, VC_VL0, 1'b1, 2'd3, 16'h1234));
        send(1'b1, ASE_WRLINE_I, ASE_4CL, 1'b1, VC_VL0, 16'h1234);
        send(1'b1, ASE_WRLINE_I, ASE_4CL, 1'b0, VC_VL0, 16'h0001);
        send(1'b1, ASE_WRLINE_I, ASE_4CL, 1'b0, VC_VL0, 16'h0002);
        t0 = cyc;
        send(1'b1, ASE_WRLINE_I, ASE_4CL, 1'b0, VC_VL0, 16'h0003);
        chk("wr4_no_proto", 32'(err_proto), 32'd0);
        wait_valid(c);
        chk("wr4_latency", 32'(c - t0), 32'd8);
        drain("wr4_drain");

        // Single write, fence, interrupt back to back
        tick();
        sb.push_back(mk(1'b1, ASE_WR_RSP, VC_VH1, 1'b0, 2'd0, 16'h0055));
        sb.push_back(mk(1'b1, ASE_WRFENCE_RSP, VC_VL0, 1'b0, 2'd0, 16'h0077));
        sb.push_back(mk(1'b1, ASE_INTR_RSP, VC_VH0, 1'b0, 2'd0, 16'h0088));
        send(1'b1, ASE_WRLINE_M, ASE_1CL, 1'b1, VC_VH1, 16'h0055);
        send(1'b1, ASE_WRFENCE, ASE_1CL, 1'b1, VC_VA, 16'h0077);
        send(1'b1, ASE_INTR_REQ, ASE_1CL, 1'b1, VC_VH0, 16'h0088);
        drain("misc_drain");

        // sop in the middle of a burst: old burst abandoned, new one completes
        tick();
        sb.push_back(mk(1'b1, ASE_WR_RSP, VC_VH0, 1'b1, 2'd1, 16'hBBBB));
        send(1'b1, ASE_WRLINE_I, ASE_2CL, 1'b1, VC_VL0, 16'hAAAA);
        send(1'b1, ASE_WRLINE_I, ASE_2CL, 1'b1, VC_VH0, 16'hBBBB);
        @(negedge clk);
        chk("resop_proto", 32'(err_proto), 32'd1);
        tick();
        send(1'b1, ASE_WRLINE_I, ASE_2CL, 1'b0, VC_VL0, 16'h0000);
        chk("resop_proto_clear", 32'(err_proto), 32'd0);
        drain("resop_drain");

        // Illegal: sop=0 write while idle, and atomic request; neither responds
        tick();
        hs0 = hs_cnt;
        send(1'b1, ASE_WRLINE_I, ASE_1CL, 1'b0, VC_VL0, 16'hDEAD);
        @(negedge clk);
        chk("nosop_proto", 32'(err_proto), 32'd1);
        @(negedge clk);
        chk("nosop_proto_pulse", 32'(err_proto), 32'd0);
        tick();
        send(1'b1, ASE_ATOMIC_REQ, ASE_1CL, 1'b1, VC_VL0, 16'hBEEF);
        @(negedge clk);
        chk("atomic_proto", 32'(err_proto), 32'd1);
        repeat (20) @(negedge clk);
        chk("illegal_no_rsp", 32'(hs_cnt), 32'(hs0));

        // Fill with ready low: almost-full at 27, overflow on the 33rd
        tick();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            sb.push_back(mk(1'b0, ASE_RD_RSP, VC_VL0, 1'b0, 2'd0, 16'(i)));
            send(1'b0, ASE_RDLINE_S, ASE_1CL, 1'b1, VC_VL0, 16'(i));
            chk("almfull", 32'(req_almfull), 32'(i >= 27));
        end
        chk("ovf_before", 32'(err_overflow), 32'd0);
        send(1'b0, ASE_RDLINE_S, ASE_1CL, 1'b1, VC_VL0, 16'd33);
        chk("ovf_set", 32'(err_overflow), 32'd1);
        rsp_ready = 1'b1;
        drain("ovf_drain");
        repeat (20) @(negedge clk);
        chk("ovf_no_extra", 32'(sb.size()), 32'd0);
        chk("ovf_sticky", 32'(err_overflow), 32'd1);
        chk("ovf_almfull_clear", 32'(req_almfull), 32'd0);

        // Reset in the middle of a 4CL read expansion
        tick();
        mon_en = 1'b0;
        send(1'b0, ASE_RDLINE_I, ASE_4CL, 1'b1, VC_VL0, 16'hD0D0);
        wait_valid(c);
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_overflow", 32'(err_overflow), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        hs0 = hs_cnt;
        mon_en = 1'b1;
        repeat (30) @(negedge clk);
        chk("postrst_no_rsp", 32'(hs_cnt), 32'(hs0));
        chk("postrst_valid", 32'(rsp_valid), 32'd0);
        chk("postrst_overflow", 32'(err_overflow), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ase_ccip_rsp_engine.md
Name: ase_ccip_rsp_engine

Overview:
- Host-side responder for the CCI-P request path. Consumes channel-tagged AFU Tx headers (ASETxHdr_t) and returns matching channel-tagged Rx response headers (ASERxHdr_t) after a programmable latency.
- Sits between the AFU Tx capture logic and the Rx driver in the ASE emulator.
- Headers only; data payload travels on a separate path.

Parameters:
- LATENCY, 8: cycles from request acceptance to earliest response. Legal range 2..32767.
- DEPTH, 32 (LATBUF_NUM_TRANSACTIONS): outstanding-entry queue depth. Power of 2.
- FULL_THRESH, DEPTH-5 (LATBUF_FULL_THRESHOLD): almost-full assertion level.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  request header valid this cycle; no backpressure
- req_hdr  in  ASE_TX_HDR_WIDTH  ASETxHdr_t; channel_id 0=C0 (read), 1=C1 (write/fence/intr)
- req_almfull  out  1  queue occupancy >= FULL_THRESH
- rsp_valid  out  1  response header valid
- rsp_hdr  out  ASE_RX_HDR_WIDTH  ASERxHdr_t response
- rsp_ready  in  1  consumer accepts rsp_hdr this cycle
- err_proto  out  1  one-cycle pulse on protocol violation
- err_overflow  out  1  sticky; set on enqueue attempt while full

Behaviour:
- Reset (async assert, sync-released): all outputs 0; queue empty; timestamp counter 0; sequencer IDLE; write tracker WR_IDLE. Reset mid-operation discards all entries and bursts in flight.
- Timestamp: 16-bit free-running counter. Each entry stores the counter value at enqueue (cycle T). Entry is eligible when the modulo-2^16 difference (now - ts) >= LATENCY, so rsp_valid first rises in cycle T+LATENCY.
- Responses are issued in order; only the queue head is examined.
- Reads (RDLINE_S/RDLINE_I, channel 0):
  - One entry per request.
  - Sequencer IDLE -> EXPAND when the head becomes eligible. Emits len+1 beats with clnum=0..len; every beat has resptype=ASE_RD_RSP, the request's mdata, and channel_id 0.
  - Head is popped on the handshake of the last beat, then the sequencer returns to IDLE.
- Write tracker (channel 1, WRLINE_I/M):
  - WR_IDLE: sop=1 with len=0 enqueues immediately.
  - WR_IDLE: sop=1 with len>0 latches mdata/vc/len, loads beat count len, and moves to WR_BURST.
  - WR_BURST: each sop=0 beat decrements the count. On the final beat, one entry is enqueued with the latched sop fields; tracker returns to WR_IDLE.
  - sop=0 in WR_IDLE: err_proto pulse, beat dropped.
  - sop=1 in WR_BURST: err_proto pulse, old burst abandoned, new burst started.
  - Write response: resptype=ASE_WR_RSP, channel_id 1. Multi-CL gives format=1, clnum=len; single gives format=0, clnum=0.
- WRFENCE: entry, then ASE_WRFENCE_RSP with mdata echoed, channel_id 1.
- INTR_REQ: entry, then ASE_INTR_RSP with mdata echoed, channel_id 1.
- ATOMIC_REQ or any undefined reqtype: err_proto pulse, no entry.
- Rx field rules for all responses:
  - vc_used = request vc, except VC_VA maps to VC_VL0.
  - poison=0, hitmiss=0, rsvd22=0.
- Handshake: rsp_valid and rsp_hdr are held stable until rsp_ready=1. A pop and a push in the same cycle leave occupancy unchanged.
- Full: an enqueue with occupancy==DEPTH is dropped and sets err_overflow. A simultaneous pop in that cycle does not rescue it.
- Empty: rsp_valid=0.
- req_almfull is registered, computed from next-state occupancy.

Optional Feature:
- ASE_RAND_LATENCY_EN
  - Defined: a 16-bit LFSR (seed 16'hACE1, reset value) adds lfsr[2:0] (0..7) to LATENCY per entry. The extra latency is stored in the entry. Ordering stays in-order, so a head's delay blocks later entries.
  - Undefined: fixed LATENCY; no LFSR logic.

Decomposition:
- Add to the shared ASE package: ase_rsp_entry_t (RxHdr_t template, 16-bit ts, 2-bit len, optional 3-bit extra latency), ASE_RSP_TS_WIDTH=16, and the rsp_seq_state_t and wr_trk_state_t enums.
- One sub-module: ase_rsp_fifo, a synchronous DEPTH x entry FIFO with count, full, empty, almfull.

Test Plan:
- Single RDLINE_I, len=ASE_1CL, mdata=16'h00A5, vc=VA, accepted at cycle 10 with LATENCY=8 -> one rsp at cycle 18: ASE_RD_RSP, clnum=0, vc_used=VL0, mdata=16'h00A5, channel_id=0.
- RDLINE_S with len=ASE_4CL, rsp_ready held 1 -> four consecutive beats with clnum 0,1,2,3 and identical mdata. With rsp_ready=0 on beat 2 for 3 cycles -> beat 2 is held stable, no beat is lost.
- 4CL write burst: sop beat mdata=16'h1234 followed by 3 sop=0 beats -> exactly one ASE_WR_RSP with format=1, clnum=3, mdata=16'h1234, LATENCY cycles after the final beat.
- Illegal sequences: sop=0 write in WR_IDLE -> err_proto pulse, no rsp. Atomic request -> err_proto pulse, no rsp.
- 32 reads with rsp_ready=0 -> req_almfull at occupancy 27. 33rd read -> err_overflow=1, still 32 responses drained in order.
- Assert rst_n low mid-EXPAND of a 4CL read -> rsp_valid=0 immediately. After release, no residual responses and err_overflow=0.
